sync_toggle_counter: RTL and testbench
======================================

# sync_toggle_counter

Synchronous modulo-N up/down counter built as a bank of toggle stages with a computed per-bit toggle-enable vector. It sits directly upstream of the T flip-flop library cells. Its `t_vec` output is the exact T input pattern a T-FF bank needs to track `count`. A terminal-count output supports cascading, and a divided-clock output toggles once per wrap.

## Interface
- `WIDTH`, 4, counter width in bits (1..16).
- `MODULUS`, 16, count range 0..MODULUS-1; legal range 2..2^WIDTH.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `en`  input  1  count enable.
- `up`  input  1  direction: 1 = increment, 0 = decrement.
- `load`  input  1  synchronous parallel load; priority over `en`.
- `load_val`  input  WIDTH  value to load.
- `count`  output  WIDTH  registered count.
- `t_vec`  output  WIDTH  combinational per-bit toggle enables for the next edge; equals count XOR next_count.
- `tc`  output  1  combinational terminal count, for cascading.
- `wrap`  output  1  registered one-cycle pulse after a wrap edge.
- `div_out`  output  1  registered; toggles on every wrap edge.

## Operation
- Reset (asynchronous, takes effect immediately, independent of `clk`) forces: `count`=0, `wrap`=0, `div_out`=0. With en=0 and load=0, `t_vec`=0 and `tc`=0.
- Action per rising edge, in priority order:
  - `load`=1: `count` <= min(load_val, MODULUS-1); an out-of-range value clamps to MODULUS-1. `wrap` <= 0. `div_out` holds.
  - else `en`=1 and `up`=1:
    - count==MODULUS-1: `count` <= 0, `wrap` <= 1, `div_out` toggles.
    - otherwise: `count` <= count+1, `wrap` <= 0.
  - else `en`=1 and `up`=0:
    - count==0: `count` <= MODULUS-1, `wrap` <= 1, `div_out` toggles.
    - otherwise: `count` <= count-1, `wrap` <= 0.
  - else (hold): `count` holds, `wrap` <= 0, `div_out` holds.
- `tc` = en & ~load & ((up & count==MODULUS-1) | (~up & count==0)).
- `t_vec` = count ^ next_count, where next_count follows the priority above.
  - For a power-of-two MODULUS counting up, bit i toggles when en & all lower bits are 1.
  - For a power-of-two MODULUS counting down, bit i toggles when en & all lower bits are 0.
  - A non-power-of-two wrap sets `t_vec` to the bits that differ between count and 0 (up) or between 0 and MODULUS-1 (down).
- `up` may change on any cycle; no pipeline state depends on the previous direction.
- All arithmetic is WIDTH bits wide. `count` never holds a value ≥ MODULUS.

## Timing
- Latency: `count` updates on the same edge that samples `en` or `load`. `wrap` and `div_out` are valid in the cycle after the wrap edge, aligned with the new `count`.
- `tc` and `t_vec` are combinational from `count`, `en`, `up`, `load`, `load_val`. They are valid before the edge they describe.
- Reset asserted mid-count clears all registers within the same cycle, with no clock needed. On deassertion, the first rising edge with en=1 and up=1 gives `count`=1.
- `div_out` period = 2·MODULUS clocks under continuous enable; duty cycle 50%.
- Simultaneous load and terminal count: load wins, `wrap`=0, `tc`=0.

## Test plan
- Reset then count up, MODULUS=10, WIDTH=4, en=1, up=1, 12 edges:
  - `count` runs 1..9, 0, 1, 2.
  - `tc`=1 only while count=9.
  - `wrap`=1 for exactly one cycle, with count=0.
  - `div_out` goes 0→1 at that point.
- Down wrap, MODULUS=10, from count=1, up=0, 3 edges:
  - `count` runs 0, 9, 8.
  - `tc`=1 while count=0.
  - Wrap edge `t_vec`=4'b1001.
- Load clamp and priority, MODULUS=10:
  - load=1, en=1, load_val=13 → `count`=9, `wrap`=0.
  - Then load=1 at count=9 with up=1 → `count`=load_val, `tc`=0.
- Power-of-two toggle vector, MODULUS=16, up=1:
  - At count=4'b0111, `t_vec`=4'b1111.
  - At count=4'b0101, `t_vec`=4'b0011.
  - Feed `t_vec` into 4 t_ff instances and check their `q` equals `count` every cycle for 40 cycles.
- Asynchronous reset mid-count: assert `reset` 3 ns after an edge with count=6 → `count`=0, `div_out`=0 before the next edge; hold en=0 → `t_vec`=0.
- Divider, MODULUS=4, continuous up for 32 cycles → `div_out` period 8 cycles, high for exactly 4 cycles each period.

Source files
------------

// File: rtl/sync_toggle_counter_if.sv
// ----------------------------------------------------------------------------
// sync_toggle_counter_if
//
// Bundles the control inputs and status outputs of sync_toggle_counter.
//
// Signals:
//   en        count enable
//   up        direction: 1 = increment, 0 = decrement
//   load      synchronous parallel load, wins over en
//   load_val  value to load (clamped to MODULUS-1 by the counter)
//   count     registered count
//   t_vec     per-bit toggle enables for the next edge (count ^ next_count)
//   tc        terminal count, combinational, for cascading
//   wrap      registered one-cycle pulse after a wrap edge
//   div_out   registered, toggles on every wrap edge
//
// Modports:
//   master  drives the controls and observes the status (bench / upstream)
//   slave   the counter itself
//
// There is no valid/ready handshake on this bus: every control is sampled
// on every rising clock edge, and every status output is always valid.
// ----------------------------------------------------------------------------
interface sync_toggle_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] t_vec;
    logic             tc;
    logic             wrap;
    logic             div_out;

    modport master (
        output en, up, load, load_val,
        input  count, t_vec, tc, wrap, div_out
    );

    modport slave (
        input  en, up, load, load_val,
        output count, t_vec, tc, wrap, div_out
    );
endinterface

// File: rtl/sync_toggle_counter.sv
// ----------------------------------------------------------------------------
// sync_toggle_counter
//
// Modulo-MODULUS up/down counter whose t_vec output is the exact T-input
// pattern a bank of T flip-flops needs to follow count. Also provides a
// terminal-count output for cascading, a one-cycle wrap pulse and a
// divided clock that toggles once per wrap.
//
// Parameters:
//   WIDTH    counter width in bits (1..16)
//   MODULUS  count range 0..MODULUS-1 (2..2^WIDTH)
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset (count, wrap, div_out -> 0)
//   bus    sync_toggle_counter_if.slave (controls in, status out)
// ----------------------------------------------------------------------------
module sync_toggle_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    sync_toggle_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] CountMax = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             div_q, div_d;

    logic             at_max;
    logic             at_zero;
    logic             tc;
    logic [WIDTH-1:0] load_clamped;

    assign at_max       = (count_q == CountMax);
    assign at_zero      = (count_q == '0);
    assign load_clamped = (bus.load_val > CountMax) ? CountMax : bus.load_val;

    // A wrap edge is exactly an edge taken while tc is high, so the wrap
    // pulse and the divider toggle are both derived from tc.
    assign tc = bus.en & ~bus.load & (bus.up ? at_max : at_zero);

    always_comb begin
        count_d = count_q;
        if (bus.load) begin
            count_d = load_clamped;
        end else if (bus.en) begin
            if (bus.up) begin
                count_d = at_max ? '0 : count_q + 1'b1;
            end else begin
                count_d = at_zero ? CountMax : count_q - 1'b1;
            end
        end
        wrap_d = tc;
        div_d  = div_q ^ tc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            div_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            div_q   <= div_d;
        end
    end

    // Toggle enables cover loads and non-power-of-two wraps too, since they
    // are taken directly from the difference of current and next count.
    assign bus.count   = count_q;
    assign bus.t_vec   = count_q ^ count_d;
    assign bus.tc      = tc;
    assign bus.wrap    = wrap_q;
    assign bus.div_out = div_q;

endmodule

// File: tb/tb_sync_toggle_counter.sv
module tb_sync_toggle_counter;
  logic clk;
  logic reset;

  int checks = 0;
  int errors = 0;

  sync_toggle_counter_if #(.WIDTH(4)) bus_a ();
  sync_toggle_counter_if #(.WIDTH(4)) bus_b ();
  sync_toggle_counter_if #(.WIDTH(3)) bus_c ();

  sync_toggle_counter #(.WIDTH(4), .MODULUS(10)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  sync_toggle_counter #(.WIDTH(4), .MODULUS(16)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));
  sync_toggle_counter #(.WIDTH(3), .MODULUS(4))  dut_c (.clk(clk), .reset(reset), .bus(bus_c));

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // T flip-flop bank fed by dut_b's toggle vector
  logic [3:0] tff_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tff_q <= '0;
    else       tff_q <= tff_q ^ bus_b.t_vec;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int up10 [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int high_cnt;

  initial begin
    bus_a.en = 0; bus_a.up = 1; bus_a.load = 0; bus_a.load_val = '0;
    bus_b.en = 0; bus_b.up = 1; bus_b.load = 0; bus_b.load_val = '0;
    bus_c.en = 0; bus_c.up = 1; bus_c.load = 0; bus_c.load_val = '0;
    reset = 1'b1;
    #2;
    chk("rst_count", bus_a.count, 4'd0);
    chk("rst_wrap", bus_a.wrap, 1'b0);
    chk("rst_div", bus_a.div_out, 1'b0);
    chk("rst_tvec", bus_a.t_vec, 4'd0);
    chk("rst_tc", bus_a.tc, 1'b0);
    #10;
    reset = 1'b0;

    // count up, MODULUS=10
    bus_a.en = 1; bus_a.up = 1;
    #1;
    chk("up_tvec0", bus_a.t_vec, 4'b0001);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("up_count", bus_a.count, 16'(up10[i]));
      chk("up_wrap", bus_a.wrap, 16'(i == 9));
      chk("up_div", bus_a.div_out, 16'(i >= 9));
      chk("up_tc", bus_a.tc, 16'(up10[i] == 9));
    end

    // down wrap from count=1
    bus_a.up = 0;
    tick();
    chk("dn_count1", bus_a.count, 4'd1);
    chk("dn_tc1", bus_a.tc, 1'b0);
    tick();
    chk("dn_count0", bus_a.count, 4'd0);
    chk("dn_tc0", bus_a.tc, 1'b1);
    chk("dn_tvec_wrap", bus_a.t_vec, 4'b1001);
    tick();
    chk("dn_count9", bus_a.count, 4'd9);
    chk("dn_wrap", bus_a.wrap, 1'b1);
    chk("dn_div", bus_a.div_out, 1'b0);
    chk("dn_tvec9", bus_a.t_vec, 4'b0001);
    chk("dn_tc9", bus_a.tc, 1'b0);
    tick();
    chk("dn_count8", bus_a.count, 4'd8);
    chk("dn_wrap8", bus_a.wrap, 1'b0);

    // load clamp and priority
    bus_a.load = 1; bus_a.load_val = 4'd13;
    #1;
    chk("ld_tvec_clamp", bus_a.t_vec, 4'b0001);
    tick();
    chk("ld_clamp", bus_a.count, 4'd9);
    chk("ld_wrap", bus_a.wrap, 1'b0);
    chk("ld_div_hold", bus_a.div_out, 1'b0);
    bus_a.up = 1; bus_a.load_val = 4'd3;
    #1;
    chk("ld_tc_prio", bus_a.tc, 1'b0);
    chk("ld_tvec_prio", bus_a.t_vec, 4'b1010);
    tick();
    chk("ld_prio_count", bus_a.count, 4'd3);
    chk("ld_prio_wrap", bus_a.wrap, 1'b0);
    chk("ld_prio_div", bus_a.div_out, 1'b0);
    bus_a.load = 0; bus_a.en = 0;
    #1;
    chk("hold_tvec", bus_a.t_vec, 4'd0);
    tick();
    chk("hold_count", bus_a.count, 4'd3);

    // power-of-two toggle vector, MODULUS=16
    bus_b.load = 1; bus_b.load_val = 4'd7;
    tick();
    chk("p2_load7", bus_b.count, 4'd7);
    bus_b.load = 0; bus_b.en = 1; bus_b.up = 1;
    #1;
    chk("p2_tvec7", bus_b.t_vec, 4'b1111);
    tick();
    chk("p2_count8", bus_b.count, 4'd8);
    bus_b.load = 1; bus_b.load_val = 4'd5;
    tick();
    bus_b.load = 0;
    #1;
    chk("p2_tvec5", bus_b.t_vec, 4'b0011);
    for (int i = 0; i < 40; i++) begin
      if (i == 25) bus_b.up = 0;
      tick();
      chk("tff_track", tff_q, bus_b.count);
    end
    chk("p2_end_count", bus_b.count, 4'd15);
    chk("p2_end_div", bus_b.div_out, 1'b0);
    bus_b.en = 0;

    // async reset mid-count: wrap once so div_out=1, then count to 6
    bus_a.load = 1; bus_a.load_val = 4'd9;
    tick();
    bus_a.load = 0; bus_a.en = 1; bus_a.up = 1;
    tick();
    chk("ar_wrap_count", bus_a.count, 4'd0);
    chk("ar_div_pre", bus_a.div_out, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    chk("ar_count6", bus_a.count, 4'd6);
    #2;
    reset = 1'b1;
    bus_a.en = 0;
    #1;
    chk("ar_count", bus_a.count, 4'd0);
    chk("ar_div", bus_a.div_out, 1'b0);
    chk("ar_wrap", bus_a.wrap, 1'b0);
    chk("ar_tvec", bus_a.t_vec, 4'd0);
    chk("ar_tc", bus_a.tc, 1'b0);
    tick();
    reset = 1'b0;
    bus_a.en = 1; bus_a.up = 1;
    tick();
    chk("ar_first_count", bus_a.count, 4'd1);
    bus_a.en = 0;

    // divider, MODULUS=4
    bus_c.en = 1; bus_c.up = 1;
    high_cnt = 0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk("div_out", bus_c.div_out, 16'((k / 4) % 2));
      if (bus_c.div_out) high_cnt++;
    end
    chk("div_high_cycles", 16'(high_cnt), 16'd16);
    chk("div_end_count", bus_c.count, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
